// File: rtl/pulpemu_rst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pulpemu_rst_seq                                            |
// | Description : Reset sequencer for the FPGA emulation top. Waits for the  |
// |               clock wizard lock, debounces the FMC reset button, holds   |
// |               the SoC in reset for HOLD_CYCLES, then releases it and     |
// |               latches the boot strap at the moment of release.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_i        in   1  single clock (pulp_soc_clk domain)                |
// |   rst_i        in   1  synchronous, active-high reset                    |
// |   pll_locked_i in   1  clock wizard lock (asynchronous)                  |
// |   ext_rst_ni   in   1  FMC reset button, active-low (async, bouncy)      |
// |   bootsel_i    in   1  boot strap, 0 = flash, 1 = JTAG (asynchronous)    |
// |   soc_rst_no   out  1  active-low SoC reset, dedicated flop              |
// |   bootsel_o    out  1  boot mode latched at release                      |
// |   rst_done_o   out  1  high while the SoC is running                     |
// |   rst_cause_o  out  2  last abort cause (PULPEMU_RST_CAUSE_EN only)      |
// |   rst_count_o  out  8  saturating count of aborts out of RUN            |
// |                         (PULPEMU_RST_CAUSE_EN only)                      |
// | Build option: define PULPEMU_RST_CAUSE_EN to add the reset-cause ports.  |
// +--------------------------------------------------------------------------+
module pulpemu_rst_seq #(
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  input  logic       bootsel_i,
  output logic       soc_rst_no,
  output logic       bootsel_o,
`ifdef PULPEMU_RST_CAUSE_EN
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o
`else
  output logic       rst_done_o
`endif
);

  localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [SYNC_STAGES-1:0] r_boot_sync;
  logic                   w_lock_s;
  logic                   w_btn_s;
  logic                   w_boot_s;

  // Button chain resets to 1 so a reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_sync <= '0;
      r_btn_sync  <= '1;
      r_boot_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0],  ext_rst_ni};
      r_boot_sync <= {r_boot_sync[SYNC_STAGES-2:0], bootsel_i};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
  assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];
  assign w_boot_s = r_boot_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------ debounce
  logic              r_btn_db;   // 1 = released
  logic [c_DB_W-1:0] r_db_cnt;
  logic              w_btn_pressed;

  // The counter measures how long btn_s has disagreed with the debounced
  // state; any agreement restarts the measurement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_DB_LAST) begin
      r_btn_db <= w_btn_s;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_btn_pressed = ~r_btn_db;

  // ----------------------------------------------------------------- FSM
  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic [c_HOLD_W-1:0]   w_hold_cnt_nxt;
  logic                  r_soc_rst_n;
  logic                  w_soc_rst_n_nxt;
  logic                  r_rst_done;
  logic                  w_rst_done_nxt;
  logic                  r_bootsel;
  logic                  w_bootsel_nxt;
  logic                  w_abort;

  assign w_abort = ~w_lock_s | w_btn_pressed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_WAIT_LOCK;
      r_hold_cnt  <= '0;
      r_soc_rst_n <= 1'b0;
      r_rst_done  <= 1'b0;
      r_bootsel   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_soc_rst_n <= w_soc_rst_n_nxt;
      r_rst_done  <= w_rst_done_nxt;
      r_bootsel   <= w_bootsel_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_soc_rst_n_nxt = r_soc_rst_n;
    w_rst_done_nxt  = r_rst_done;
    w_bootsel_nxt   = r_bootsel;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s && !w_btn_pressed) begin
          w_state_nxt    = ST_HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        // Abort wins over release when both fall on the last hold cycle.
        if (w_abort) begin
          w_state_nxt     = ST_WAIT_LOCK;
          w_soc_rst_n_nxt = 1'b0;
          w_rst_done_nxt  = 1'b0;
        end else if (r_hold_cnt == c_HOLD_LAST) begin
          w_state_nxt     = ST_RUN;
          w_soc_rst_n_nxt = 1'b1;
          w_rst_done_nxt  = 1'b1;
          w_bootsel_nxt   = w_boot_s;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt     = ST_WAIT_LOCK;
          w_soc_rst_n_nxt = 1'b0;
          w_rst_done_nxt  = 1'b0;
        end
      end
      default: begin
        // Unused encoding: fall back to the safe, reset-asserted state.
        w_state_nxt     = ST_WAIT_LOCK;
        w_soc_rst_n_nxt = 1'b0;
        w_rst_done_nxt  = 1'b0;
      end
    endcase
  end

  assign soc_rst_no = r_soc_rst_n;
  assign rst_done_o = r_rst_done;
  assign bootsel_o  = r_bootsel;

`ifdef PULPEMU_RST_CAUSE_EN
  // ---------------------------------------------------------- reset cause
  logic [1:0] r_cause;
  logic [7:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cause <= 2'b00;
      r_count <= 8'd0;
    end else if (w_abort && (r_state == ST_HOLD || r_state == ST_RUN)) begin
      // Lock loss takes priority when both abort sources coincide.
      r_cause <= (!w_lock_s) ? 2'b01 : 2'b10;
      if (r_state == ST_RUN && r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign rst_cause_o = r_cause;
  assign rst_count_o = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_rst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pulpemu_rst_seq                                         |
// | Description : Self-checking bench for pulpemu_rst_seq. Expected values   |
// |               come from latency formulas derived from the sequencing     |
// |               rules and from a small abort-count model.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pulpemu_rst_seq;

  localparam int HOLD = 16;
  localparam int DEB  = 256;
  localparam int SYNC = 2;
  // Edges from an input change to the resulting soc_rst_no change.
  localparam int REL_LAT  = SYNC + 1 + HOLD;  // lock seen -> release
  localparam int LOSS_LAT = SYNC + 1;         // lock lost -> reset
  localparam int BTN_LAT  = SYNC + DEB + 1;   // sustained press -> reset

  logic clk_i = 1'b0;
  logic rst_i;
  logic pll_locked_i;
  logic ext_rst_ni;
  logic bootsel_i;
  logic soc_rst_no;
  logic bootsel_o;
  logic rst_done_o;
`ifdef PULPEMU_RST_CAUSE_EN
  logic [1:0] rst_cause_o;
  logic [7:0] rst_count_o;
  int         exp_count;
  logic [1:0] exp_cause;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pulpemu_rst_seq #(
    .HOLD_CYCLES     (HOLD),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pll_locked_i (pll_locked_i),
    .ext_rst_ni   (ext_rst_ni),
    .bootsel_i    (bootsel_i),
    .soc_rst_no   (soc_rst_no),
    .bootsel_o    (bootsel_o),
`ifdef PULPEMU_RST_CAUSE_EN
    .rst_done_o   (rst_done_o),
    .rst_cause_o  (rst_cause_o),
    .rst_count_o  (rst_count_o)
`else
    .rst_done_o   (rst_done_o)
`endif
  );

  // One active edge, then settle on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Counts edges until soc_rst_no reaches lvl; returns max_edges+1 on timeout.
  task automatic edges_until(input logic lvl, input int max_edges, output int n);
    n = 0;
    while ((soc_rst_no !== lvl) && (n <= max_edges)) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; pll_locked_i = 1'b1; ext_rst_ni = 1'b0; bootsel_i = 1'b1;
    repeat (3) tick();
    checks++; if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL reset_soc_rst_n got %b want 0", soc_rst_no); end
    checks++; if (rst_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", rst_done_o); end
    checks++; if (bootsel_o !== 1'b0) begin errors++; $display("FAIL reset_bootsel got %b want 0", bootsel_o); end
`ifdef PULPEMU_RST_CAUSE_EN
    exp_cause = 2'b00; exp_count = 0;
    checks++; if (rst_cause_o !== exp_cause) begin errors++; $display("FAIL reset_cause got %b want %b", rst_cause_o, exp_cause); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL reset_count got %0d want %0d", rst_count_o, exp_count); end
`endif
    // Without lock the SoC must stay in reset indefinitely.
    pll_locked_i = 1'b0; ext_rst_ni = 1'b1; rst_i = 1'b0;
    repeat (60) tick();
    checks++; if (soc_rst_no !== 1'b0) begin errors++; $display("FAIL nolock_held got %b want 0", soc_rst_no); end
  endtask

  task automatic test_release_latency();
    int   n;
    logic b;
    for (int it = 0; it < 3; it++) begin
      b = 1'($urandom_range(0, 1));
      bootsel_i = b; pll_locked_i = 1'b1; ext_rst_ni = 1'b1;
      rst_i = 1'b1; tick(); rst_i = 1'b0;
`ifdef PULPEMU_RST_CAUSE_EN
      exp_cause = 2'b00; exp_count = 0;
`endif
      edges_until(1'b1, 60, n);
      checks++; if (n != REL_LAT) begin errors++; $display("FAIL release_edge[%0d] got %0d want %0d", it, n, REL_LAT); end
      checks++; if (rst_done_o !== 1'b1) begin errors++; $display("FAIL release_done[%0d] got %b want 1", it, rst_done_o); end
      checks++; if (bootsel_o !== b) begin errors++; $display("FAIL release_bootsel[%0d] got %b want %b", it, bootsel_o, b); end
    end
  endtask

  task automatic test_bootsel_latch();
    int n;
    int bad;
    bootsel_i = 1'b1; rst_i = 1'b1; tick(); rst_i = 1'b0;
`ifdef PULPEMU_RST_CAUSE_EN
    exp_cause = 2'b00; exp_count = 0;
`endif
    edges_until(1'b1, 60, n);
    checks++; if (n != REL_LAT || bootsel_o !== 1'b1) begin errors++; $display("FAIL boot_release got edge %0d boot %b want edge %0d boot 1", n, bootsel_o, REL_LAT); end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      bootsel_i = 1'($urandom_range(0, 1));
      tick();
      if (bootsel_o !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL boot_stable_run got %0d changed cycles want 0", bad); end
    // Lock loss from RUN; strap now 0 but latched value must persist.
    bootsel_i = 1'b0; pll_locked_i = 1'b0;
    edges_until(1'b0, 20, n);
    checks++; if (n != LOSS_LAT) begin errors++; $display("FAIL lockloss_edge got %0d want %0d", n, LOSS_LAT); end
    checks++; if (rst_done_o !== 1'b0) begin errors++; $display("FAIL lockloss_done got %b want 0", rst_done_o); end
    checks++; if (bootsel_o !== 1'b1) begin errors++; $display("FAIL lockloss_boot_keep got %b want 1", bootsel_o); end
`ifdef PULPEMU_RST_CAUSE_EN
    exp_cause = 2'b01; exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks++; if (rst_cause_o !== exp_cause) begin errors++; $display("FAIL lockloss_cause got %b want %b", rst_cause_o, exp_cause); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL lockloss_count got %0d want %0d", rst_count_o, exp_count); end
`endif
    pll_locked_i = 1'b1;
    edges_until(1'b1, 60, n);
    checks++; if (n != REL_LAT) begin errors++; $display("FAIL relock_edge got %0d want %0d", n, REL_LAT); end
    checks++; if (bootsel_o !== 1'b0) begin errors++; $display("FAIL relock_boot got %b want 0", bootsel_o); end
  endtask

  task automatic test_bounce();
    int elapsed;
    int p;
    int bad;
    elapsed = 0; bad = 0;
    while (elapsed < 600) begin
      ext_rst_ni = ~ext_rst_ni;
      p = $urandom_range(5, 40);
      for (int i = 0; i < p; i++) begin
        tick();
        if (soc_rst_no !== 1'b1) bad++;
      end
      elapsed += p;
    end
    ext_rst_ni = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (soc_rst_no !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_no_reset got %0d reset cycles want 0", bad); end
    checks++; if (rst_done_o !== 1'b1) begin errors++; $display("FAIL bounce_done got %b want 1", rst_done_o); end
  endtask

  task automatic test_button_hold();
    int n;
    int bad;
    int extra;
    // One cycle short of the debounce window: ignored.
    bad = 0;
    ext_rst_ni = 1'b0;
    repeat (DEB - 1) tick();
    ext_rst_ni = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (soc_rst_no !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL short_press got %0d reset cycles want 0", bad); end
    // Sustained press.
    ext_rst_ni = 1'b0;
    edges_until(1'b0, 400, n);
    checks++; if (n != BTN_LAT) begin errors++; $display("FAIL press_edge got %0d want %0d", n, BTN_LAT); end
`ifdef PULPEMU_RST_CAUSE_EN
    exp_cause = 2'b10; exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks++; if (rst_cause_o !== exp_cause) begin errors++; $display("FAIL press_cause got %b want %b", rst_cause_o, exp_cause); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL press_count got %0d want %0d", rst_count_o, exp_count); end
`endif
    extra = $urandom_range(300, 340) - n;
    repeat (extra) tick();
    checks++; if (soc_rst_no !== 1'b0 || rst_done_o !== 1'b0) begin errors++; $display("FAIL press_held got soc %b done %b want 0 0", soc_rst_no, rst_done_o); end
    // Release: debounce back to released, then a full fresh hold.
    ext_rst_ni = 1'b1;
    edges_until(1'b1, 600, n);
    checks++; if (n != BTN_LAT + HOLD) begin errors++; $display("FAIL unpress_edge got %0d want %0d", n, BTN_LAT + HOLD); end
  endtask

  task automatic test_hold_abort();
    int n;
    int a;
    int d;
    int bad;
    pll_locked_i = 1'b1; ext_rst_ni = 1'b1; bootsel_i = 1'b0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
`ifdef PULPEMU_RST_CAUSE_EN
    exp_cause = 2'b00; exp_count = 0;
`endif
    a = $urandom_range(4, 15);  // HOLD was entered on edge 3, count = a-3
    d = $urandom_range(1, 8);
    bad = 0;
    repeat (a) tick();
    pll_locked_i = 1'b0;
    for (int i = 0; i < d; i++) begin
      tick();
      if (soc_rst_no !== 1'b0) bad++;
    end
    pll_locked_i = 1'b1;
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_abort_no_release got %0d cycles want 0", bad); end
    edges_until(1'b1, 60, n);
    checks++; if (n != REL_LAT) begin errors++; $display("FAIL hold_restart_edge got %0d want %0d (a=%0d d=%0d)", n, REL_LAT, a, d); end
`ifdef PULPEMU_RST_CAUSE_EN
    exp_cause = 2'b01;  // abort from HOLD: cause updates, count does not
    checks++; if (rst_cause_o !== exp_cause) begin errors++; $display("FAIL hold_abort_cause got %b want %b", rst_cause_o, exp_cause); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL hold_abort_count got %0d want %0d", rst_count_o, exp_count); end
`endif
  endtask

  task automatic test_cause();
`ifdef PULPEMU_RST_CAUSE_EN
    int n;
    int bad;
    int to;
    // Debounced press and lock loss land on the same FSM edge.
    bad = 0;
    ext_rst_ni = 1'b0;
    for (int i = 0; i < DEB; i++) begin
      tick();
      if (soc_rst_no !== 1'b1) bad++;
    end
    pll_locked_i = 1'b0;
    edges_until(1'b0, 20, n);
    checks++; if (bad != 0 || n + DEB != BTN_LAT) begin errors++; $display("FAIL both_edge got %0d early %0d want %0d", n + DEB, bad, BTN_LAT); end
    exp_cause = 2'b01; exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    checks++; if (rst_cause_o !== exp_cause) begin errors++; $display("FAIL both_cause got %b want %b", rst_cause_o, exp_cause); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL both_count got %0d want %0d", rst_count_o, exp_count); end
    ext_rst_ni = 1'b1; pll_locked_i = 1'b1;
    edges_until(1'b1, 600, n);
    checks++; if (n != BTN_LAT + HOLD) begin errors++; $display("FAIL both_recover got %0d want %0d", n, BTN_LAT + HOLD); end
    // Many lock-loss aborts: count must saturate.
    to = 0;
    for (int k = 0; k < 300; k++) begin
      pll_locked_i = 1'b0;
      edges_until(1'b0, 20, n);
      if (n != LOSS_LAT) to++;
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      pll_locked_i = 1'b1;
      edges_until(1'b1, 60, n);
      if (n != REL_LAT) to++;
    end
    checks++; if (to != 0) begin errors++; $display("FAIL abort_loop got %0d bad latencies want 0", to); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL count_saturate got %0d want %0d", rst_count_o, exp_count); end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    exp_cause = 2'b00; exp_count = 0;
    checks++; if (rst_cause_o !== exp_cause) begin errors++; $display("FAIL rst_cause_clear got %b want %b", rst_cause_o, exp_cause); end
    checks++; if (rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL rst_count_clear got %0d want %0d", rst_count_o, exp_count); end
    checks++; if (soc_rst_no !== 1'b0 || bootsel_o !== 1'b0) begin errors++; $display("FAIL rst_midrun got soc %b boot %b want 0 0", soc_rst_no, bootsel_o); end
`else
    int n;
    // Mid-run reset must drop everything on the next edge.
    bootsel_i = 1'b1;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    edges_until(1'b1, 60, n);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    checks++; if (soc_rst_no !== 1'b0 || rst_done_o !== 1'b0 || bootsel_o !== 1'b0) begin errors++; $display("FAIL rst_midrun got soc %b done %b boot %b want 0 0 0", soc_rst_no, rst_done_o, bootsel_o); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; pll_locked_i = 1'b0; ext_rst_ni = 1'b1; bootsel_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_release_latency();
    test_bootsel_latch();
    test_bounce();
    test_button_hold();
    test_hold_abort();
    test_cause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
